// File: rtl/audio_pwm_out_pkg.sv
// Shared definitions for the audio output path: default sample width, sample type
// and the midscale (silence) level for unsigned audio.
package audio_pkg;

    localparam int unsigned AUDIO_WIDTH = 8;

    typedef logic [AUDIO_WIDTH-1:0] sample_t;

    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/audio_pwm_out_tick_gen.sv
// Prescale divider: pulses tick once every PRESCALE clk cycles (every cycle when PRESCALE=1).
// Shared with the note frequency dividers.
module audio_tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A 1-bit counter is kept even for PRESCALE=1; it simply never leaves zero.
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] pre_cnt;

    assign tick = (pre_cnt == CW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/audio_pwm_out.sv
// Audio output stage: one-entry sample buffer feeding a frame-synchronous PWM duty register.
// Build option AUDIO_PWM_MUTE_ON_UNDERRUN_EN: drive midscale duty on underrun instead of holding.
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH    = AUDIO_WIDTH,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             frame_strobe,
    output logic             underrun
);

`ifdef AUDIO_PWM_MUTE_ON_UNDERRUN_EN
    localparam logic [WIDTH-1:0] MUTE_DUTY = WIDTH'(midscale(WIDTH));
`endif

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_active;
    logic [WIDTH-1:0] buf_q;
    logic             buf_full;
    logic             tick;
    logic             boundary;
    logic             xfer;

    audio_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign sample_ready = !buf_full;
    assign xfer         = sample_valid && sample_ready;
    assign boundary     = tick && (cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            duty_active  <= '0;
            buf_q        <= '0;
            buf_full     <= 1'b0;
            pwm_out      <= 1'b0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            pwm_out      <= (cnt < duty_active);
            frame_strobe <= boundary;
            underrun     <= boundary && !buf_full;

            if (tick) begin
                cnt <= cnt + WIDTH'(1);
            end

            // A full buffer blocks transfers, so a drain and a fill never meet in one cycle.
            if (xfer) begin
                buf_q    <= sample_in;
                buf_full <= 1'b1;
            end else if (boundary && buf_full) begin
                buf_full <= 1'b0;
            end

            if (boundary) begin
                if (buf_full) begin
                    duty_active <= buf_q;
                end
`ifdef AUDIO_PWM_MUTE_ON_UNDERRUN_EN
                else begin
                    duty_active <= MUTE_DUTY;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Bench for audio_pwm_out: PRESCALE=1 and PRESCALE=3 instances checked every cycle against
// an arithmetic frame model, plus frame-level duty/handshake/underrun sequences.
module tb_audio_pwm_out;
    import audio_pkg::*;

`ifdef AUDIO_PWM_MUTE_ON_UNDERRUN_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    sample_t sample_in = '0;
    logic    sample_valid = 1'b0;
    logic    ready1, pwm1, fs1, ur1;
    logic    ready3, pwm3, fs3, ur3;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    audio_pwm_out #(.WIDTH(8), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(ready1), .pwm_out(pwm1), .frame_strobe(fs1), .underrun(ur1)
    );

    audio_pwm_out #(.WIDTH(8), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(ready3), .pwm_out(pwm3), .frame_strobe(fs3), .underrun(ur3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference model: edge k after reset release sees cnt = (k/P) mod 256 and a frame
    // boundary when k mod (256*P) == 256*P-1; a one-deep pending slot feeds the duty.
    function automatic int unsigned ps(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit is_bnd(input int unsigned kk, input int unsigned p);
        return (kk % (256 * p)) == (256 * p - 1);
    endfunction

    int unsigned k[2];
    logic        mfull[2];
    logic [7:0]  mbuf[2];
    logic [7:0]  mduty[2];
    logic        epwm[2], efs[2], eur[2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                k[i] <= 0; mfull[i] <= 1'b0; mbuf[i] <= '0; mduty[i] <= '0;
                epwm[i] <= 1'b0; efs[i] <= 1'b0; eur[i] <= 1'b0;
            end else begin
                epwm[i] <= ((k[i] / ps(i)) % 256) < 32'(mduty[i]);
                efs[i]  <= is_bnd(k[i], ps(i));
                eur[i]  <= is_bnd(k[i], ps(i)) && !mfull[i];
                if (is_bnd(k[i], ps(i)) && mfull[i]) begin
                    mduty[i] <= mbuf[i];
                    mfull[i] <= 1'b0;
                end else if (is_bnd(k[i], ps(i)) && MUTE) begin
                    mduty[i] <= 8'h80;
                end
                if (sample_valid && !mfull[i]) begin
                    mbuf[i]  <= sample_in;
                    mfull[i] <= 1'b1;
                end
                k[i] <= k[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cycle_p1 {ready,pwm,strobe,underrun}", {28'd0, ready1, pwm1, fs1, ur1},
                {28'd0, !mfull[0], epwm[0], efs[0], eur[0]});
            chk("cycle_p3 {ready,pwm,strobe,underrun}", {28'd0, ready3, pwm3, fs3, ur3},
                {28'd0, !mfull[1], epwm[1], efs[1], eur[1]});
        end
    end

    // Stimulus helpers: one call per clk, inputs changed on the falling edge.
    bit      sending = 1'b0;
    sample_t sval = '0;
    bit      bp_mode = 1'b0;
    bit      acc_pending = 1'b0;
    sample_t acc_q[$];

    task automatic cyc();
        @(negedge clk);
        if (bp_mode) begin
            if (acc_pending) begin
                chk("bp_ready_drop", 32'(ready1), 32'd0);
                sample_in   = sample_in + 8'd37;
                acc_pending = 1'b0;
            end
            if (ready1) begin
                acc_q.push_back(sample_in);
                acc_pending = 1'b1;
            end
            sample_valid = 1'b1;
        end else if (sending && ready1) begin
            sample_valid = 1'b1;
            sample_in    = sval;
            sending      = 1'b0;
        end else begin
            sample_valid = 1'b0;
            sample_in    = sample_t'($urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; sample_valid = 1'b0; sending = 1'b0; bp_mode = 1'b0;
        #1 chk_on = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic wait_strobe(input int lim);
        int n = 0;
        do begin cyc(); n++; end while (!fs1 && n < lim);
        total++;
        if (!fs1) begin
            bad++;
            $display("FAIL strobe_wait actual=none required=strobe within %0d cycles", lim);
        end
    endtask

    task automatic count_frame(output int hi, output int first);
        hi = 0; first = -1;
        for (int j = 1; j <= 256; j++) begin
            cyc();
            if (pwm1) begin
                hi++;
                if (first < 0) first = j;
            end
        end
    endtask

    typedef struct {
        bit         feed;
        logic [7:0] smp;
        int         exp_high;
        logic       exp_ur;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl[NV];

    initial begin
        int hi, first, n, hold;
        int rate[4];
        sample_t expv;

        hold = MUTE ? 128 : 16;
        tbl[0] = '{1'b1, 8'h40, 64,   1'b0};
        tbl[1] = '{1'b1, 8'h40, 64,   1'b0};
        tbl[2] = '{1'b1, 8'h00, 0,    1'b0};
        tbl[3] = '{1'b1, 8'hFF, 255,  1'b0};
        tbl[4] = '{1'b1, 8'h80, 128,  1'b0};
        tbl[5] = '{1'b0, 8'h00, 128,  1'b1};
        tbl[6] = '{1'b0, 8'h00, 128,  1'b1};
        tbl[7] = '{1'b1, 8'h10, 16,   1'b0};
        tbl[8] = '{1'b0, 8'h00, hold, 1'b1};
        tbl[9] = '{1'b0, 8'h00, hold, 1'b1};

        // Reset mid-frame with a full buffer and pwm high.
        do_reset();
        sending = 1'b1; sval = 8'hFF;
        wait_strobe(600);
        sending = 1'b1; sval = 8'h20;
        repeat (100) cyc();
        chk("pre_reset_pwm", 32'(pwm1), 32'd1);
        chk("pre_reset_ready", 32'(ready1), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_pwm", 32'(pwm1), 32'd0);
        chk("rst_strobe", 32'(fs1), 32'd0);
        chk("rst_underrun", 32'(ur1), 32'd0);
        chk("rst_ready", 32'(ready1), 32'd1);
        chk("rst_pwm_p3", 32'(pwm3), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        cyc();
        chk("post_rst_ready", 32'(ready1), 32'd1);
        wait_strobe(600);
        chk("post_rst_underrun", 32'(ur1), 32'd1);
        count_frame(hi, first);
        chk("post_rst_duty0", 32'(hi), 32'd0);

        // Table-driven frames: duty accuracy, extremes, underrun hold/mute.
        do_reset();
        sending = tbl[0].feed; sval = tbl[0].smp;
        wait_strobe(600);
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("tbl%0d_underrun", i), 32'(ur1), 32'(tbl[i].exp_ur));
            if (i + 1 < NV && tbl[i + 1].feed) begin
                sending = 1'b1; sval = tbl[i + 1].smp;
            end
            count_frame(hi, first);
            chk($sformatf("tbl%0d_high", i), 32'(hi), 32'(tbl[i].exp_high));
            if (tbl[i].exp_high > 0) chk($sformatf("tbl%0d_first", i), 32'(first), 32'd1);
            chk($sformatf("tbl%0d_frame_len", i), 32'(fs1), 32'd1);
        end

        // Transfer in the boundary cycle with an empty buffer.
        repeat (254) cyc();
        sending = 1'b1; sval = 8'h33;
        cyc();
        cyc();
        chk("simul_strobe", 32'(fs1), 32'd1);
        chk("simul_underrun", 32'(ur1), 32'd1);
        chk("simul_ready", 32'(ready1), 32'd0);
        count_frame(hi, first);
        chk("simul_hold_high", 32'(hi), 32'(hold));
        chk("simul_next_underrun", 32'(ur1), 32'd0);
        count_frame(hi, first);
        chk("simul_applied_high", 32'(hi), 32'd51);

        // Backpressure: valid held high, data advances on each accept.
        do_reset();
        acc_q.delete(); acc_pending = 1'b0; sample_in = 8'd30; bp_mode = 1'b1;
        wait_strobe(600);
        for (int f = 0; f < 4; f++) begin
            chk($sformatf("bp%0d_ready_rise", f), 32'(ready1), 32'd1);
            expv = (acc_q.size() > 0) ? acc_q.pop_front() : 8'hxx;
            count_frame(hi, first);
            chk($sformatf("bp%0d_high", f), 32'(hi), 32'(expv));
        end
        bp_mode = 1'b0;

        // PRESCALE=3 frame length.
        do_reset();
        n = 0;
        do begin cyc(); n++; end while (!fs3 && n < 1000);
        n = 0;
        do begin cyc(); n++; end while (!fs3 && n < 1000);
        chk("p3_frame_len", 32'(n), 32'd768);

        // Randomized traffic at varying offered rates, one reset mid-run.
        do_reset();
        rate = '{2, 10, 60, 95};
        for (int c = 0; c < 4000; c++) begin
            if (c == 2500) begin
                @(posedge clk); #2 rst = 1'b1;
                @(posedge clk); #2 rst = 1'b0;
            end
            @(negedge clk);
            sample_valid = ($urandom_range(0, 99) < rate[c / 1000]);
            sample_in    = sample_t'($urandom);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
